// File: rtl/cam_search_engine_if.sv
// Key lookup and entry write bundle for the CAM search engine.
// The master drives writes and keys; the slave returns results.
interface cam_search_engine_if #(
  parameter int DATA_WIDTH = 14,
  parameter int ADDR_WIDTH = 12
);
  logic                  we;
  logic                  clr_en;
  logic [DATA_WIDTH-1:0] din;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  key_valid;
  logic [DATA_WIDTH-1:0] key;
  logic                  key_ready;
  logic                  match_valid;
  logic                  match_found;
  logic [ADDR_WIDTH-1:0] match_addr;
  logic                  busy;

  modport master (
    output we, clr_en, din, addr, key_valid, key,
    input  key_ready, match_valid, match_found, match_addr, busy
  );

  modport slave (
    input  we, clr_en, din, addr, key_valid, key,
    output key_ready, match_valid, match_found, match_addr, busy
  );
endinterface

// File: rtl/cam_search_engine.sv
// Key-to-address lookup: scans 2**LANE_WIDTH entries per cycle
// and reports the lowest valid address holding the key.
module cam_search_engine #(
  parameter int DATA_WIDTH = 14,
  parameter int ADDR_WIDTH = 12,
  parameter int LANE_WIDTH = 4
) (
  input logic               clk,
  input logic               rst,
  cam_search_engine_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int NL    = 1 << LANE_WIDTH;
  localparam int NSEG  = 1 << (ADDR_WIDTH - LANE_WIDTH);
  localparam int SW    = (ADDR_WIDTH > LANE_WIDTH) ?
                         (ADDR_WIDTH - LANE_WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]      valid_q;

  state_e                state_q, state_d;
  logic [SW-1:0]         seg_q, seg_d;
  logic [DATA_WIDTH-1:0] key_q, key_d;
  logic                  found_q, found_d;
  logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;

  logic                  hit;
  logic [ADDR_WIDTH-1:0] hit_addr;
  logic [ADDR_WIDTH-1:0] idx;

  // Data words carry no reset; only the valid bits do.
  always_ff @(posedge clk) begin
    if (bus.we) mem_q[bus.addr] <= bus.din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (bus.we) begin
      valid_q[bus.addr] <= 1'b1;
    end else if (bus.clr_en) begin
      valid_q[bus.addr] <= 1'b0;
    end
  end

  // Descending walk so the lowest hitting lane wins.
  always_comb begin
    hit      = 1'b0;
    hit_addr = '0;
    idx      = '0;
    for (int l = NL - 1; l >= 0; l--) begin
      idx = ADDR_WIDTH'(int'(seg_q) * NL + l);
      if (valid_q[idx] && mem_q[idx] == key_q) begin
        hit      = 1'b1;
        hit_addr = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    seg_d   = seg_q;
    key_d   = key_q;
    found_d = found_q;
    maddr_d = maddr_q;
    unique case (state_q)
      IDLE: begin
        if (bus.key_valid) begin
          key_d   = bus.key;
          seg_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (hit) begin
          found_d = 1'b1;
          maddr_d = hit_addr;
          state_d = DONE;
        end else if (seg_q == SW'(NSEG - 1)) begin
          found_d = 1'b0;
          maddr_d = '0;
          state_d = DONE;
        end else begin
          seg_d = seg_q + SW'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      seg_q   <= '0;
      key_q   <= '0;
      found_q <= 1'b0;
      maddr_q <= '0;
    end else begin
      state_q <= state_d;
      seg_q   <= seg_d;
      key_q   <= key_d;
      found_q <= found_d;
      maddr_q <= maddr_d;
    end
  end

  assign bus.key_ready   = (state_q == IDLE) && !rst;
  assign bus.match_valid = (state_q == DONE) && !rst;
  assign bus.busy        = (state_q != IDLE) && !rst;
  assign bus.match_found = found_q;
  assign bus.match_addr  = maddr_q;
endmodule

// File: tb/tb_cam_search_engine.sv
// Directed bench for cam_search_engine: vector table of searches
// plus hand sequences for write races and mid-scan reset.
module tb_cam_search_engine;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  cam_search_engine_if #(.DATA_WIDTH(14), .ADDR_WIDTH(12)) bus ();

  cam_search_engine #(
    .DATA_WIDTH(14),
    .ADDR_WIDTH(12),
    .LANE_WIDTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [11:0] waddr;
    logic [13:0] wdata;
    logic [13:0] key;
    logic        exp_found;
    logic [11:0] exp_addr;
    int          exp_lat;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [11:0] a, input logic [13:0] d);
    bus.we   = 1'b1;
    bus.addr = a;
    bus.din  = d;
    @(posedge clk); #1;
    bus.we   = 1'b0;
  endtask

  task automatic clr(input logic [11:0] a);
    bus.clr_en = 1'b1;
    bus.addr   = a;
    @(posedge clk); #1;
    bus.clr_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic accept(input string name, input logic [13:0] k);
    int n;
    n = 0;
    while (!bus.key_ready && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_ready"}, 32'(bus.key_ready), 32'd1);
    bus.key_valid = 1'b1;
    bus.key       = k;
    @(posedge clk); #1;
    bus.key_valid = 1'b0;
    bus.key       = 14'h3AAA;
  endtask

  task automatic wait_done(input string name, input int k0,
                           output int lat);
    int  k;
    logic ok;
    k   = k0;
    lat = -1;
    ok  = 1'b1;
    while (k < 400) begin
      @(posedge clk); #1;
      k++;
      if (!bus.busy || bus.key_ready) ok = 1'b0;
      if (bus.match_valid) begin
        lat = k;
        break;
      end
    end
    chk({name, "_busy"}, 32'(ok), 32'd1);
  endtask

  task automatic finish_check(input string name, input int lat,
                              input logic ef, input logic [11:0] ea,
                              input int el);
    chk({name, "_lat"}, 32'(lat), 32'(el));
    chk({name, "_found"}, 32'(bus.match_found), 32'(ef));
    chk({name, "_addr"}, 32'(bus.match_addr), 32'(ea));
    @(posedge clk); #1;
    chk({name, "_strobe1"}, 32'(bus.match_valid), 32'd0);
    chk({name, "_hold"}, {19'd0, bus.match_found, bus.match_addr},
        {19'd0, ef, ea});
    chk({name, "_rdy"}, 32'(bus.key_ready), 32'd1);
  endtask

  task automatic search(input string name, input logic [13:0] k,
                        input logic ef, input logic [11:0] ea,
                        input int el);
    int lat;
    accept(name, k);
    wait_done(name, 0, lat);
    finish_check(name, lat, ef, ea, el);
  endtask

  initial begin
    int   lat;
    logic seen;
    checks = 0;
    errors = 0;

    vecs[0] = '{0, 12'h000, 14'h0000, 14'h0000, 1'b0, 12'h000, 256};
    vecs[1] = '{1, 12'h025, 14'h1234, 14'h1234, 1'b1, 12'h025, 3};
    vecs[2] = '{1, 12'h300, 14'h0ABC, 14'h0ABC, 1'b1, 12'h300, 49};
    vecs[3] = '{1, 12'h07F, 14'h0ABC, 14'h0ABC, 1'b1, 12'h07F, 8};
    vecs[4] = '{2, 12'h07F, 14'h0000, 14'h0ABC, 1'b1, 12'h300, 49};
    vecs[5] = '{1, 12'h000, 14'h3FFF, 14'h3FFF, 1'b1, 12'h000, 1};
    vecs[6] = '{1, 12'h00F, 14'h3FFF, 14'h3FFF, 1'b1, 12'h000, 1};
    vecs[7] = '{2, 12'h000, 14'h0000, 14'h3FFF, 1'b1, 12'h00F, 1};
    vecs[8] = '{1, 12'hFFF, 14'h1555, 14'h1555, 1'b1, 12'hFFF, 256};
    vecs[9] = '{0, 12'h000, 14'h0000, 14'h0001, 1'b0, 12'h000, 256};

    rst           = 1'b1;
    bus.we        = 1'b0;
    bus.clr_en    = 1'b0;
    bus.din       = '0;
    bus.addr      = '0;
    bus.key_valid = 1'b0;
    bus.key       = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready_low", 32'(bus.key_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_ready", 32'(bus.key_ready), 32'd1);
    chk("rst_outs", {28'd0, bus.match_valid, bus.match_found, bus.busy,
        1'b0}, 32'd0);
    chk("rst_addr", 32'(bus.match_addr), 32'd0);

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].op == 2'd1) wr(vecs[i].waddr, vecs[i].wdata);
      if (vecs[i].op == 2'd2) clr(vecs[i].waddr);
      search($sformatf("vec%0d", i), vecs[i].key, vecs[i].exp_found,
             vecs[i].exp_addr, vecs[i].exp_lat);
    end

    // Writes landing behind the scan pointer: 0xFFF seen, 0x005 not.
    do_reset();
    accept("raceA", 14'h2222);
    repeat (10) begin @(posedge clk); #1; end
    bus.we   = 1'b1;
    bus.din  = 14'h2222;
    bus.addr = 12'hFFF;
    @(posedge clk); #1;
    bus.clr_en = 1'b1;
    bus.addr   = 12'h005;
    @(posedge clk); #1;
    bus.we     = 1'b0;
    bus.clr_en = 1'b0;
    wait_done("raceA", 12, lat);
    finish_check("raceA", lat, 1'b1, 12'hFFF, 256);
    search("raceA_wins", 14'h2222, 1'b1, 12'h005, 1);

    // Write during the compare of its own segment is not seen.
    accept("raceB", 14'h0111);
    repeat (3) begin @(posedge clk); #1; end
    bus.we   = 1'b1;
    bus.din  = 14'h0111;
    bus.addr = 12'h035;
    @(posedge clk); #1;
    bus.we = 1'b0;
    wait_done("raceB", 4, lat);
    finish_check("raceB", lat, 1'b0, 12'h000, 256);
    search("raceB_again", 14'h0111, 1'b1, 12'h035, 4);

    // Reset in the middle of a scan.
    wr(12'hFF0, 14'h0555);
    accept("rstmid", 14'h0555);
    repeat (50) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("rstmid_ready_low", 32'(bus.key_ready), 32'd0);
    chk("rstmid_nostrobe", 32'(bus.match_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rstmid_ready", 32'(bus.key_ready), 32'd1);
    chk("rstmid_busy", 32'(bus.busy), 32'd0);
    seen = 1'b0;
    repeat (300) begin
      @(posedge clk); #1;
      if (bus.match_valid) seen = 1'b1;
    end
    chk("rstmid_no_result", 32'(seen), 32'd0);
    search("rstmid_miss1", 14'h0555, 1'b0, 12'h000, 256);
    search("rstmid_miss2", 14'h0111, 1'b0, 12'h000, 256);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/cam_search_engine.md
# cam_search_engine

Content-addressed lookup block: where a RAM returns data for an address, this block returns the lowest address holding a given key. It holds DATA_WIDTH-bit entries with per-entry valid bits, accepts writes and invalidations through an addressed port, and resolves search keys by scanning 2**LANE_WIDTH entries per cycle under a valid/ready handshake. It sits beside the addressed RAM in the CAM subsystem as its key-to-address lookup path.

## Interface
- DATA_WIDTH, 14, entry and key width
- ADDR_WIDTH, 12, address width; depth = 2**ADDR_WIDTH
- LANE_WIDTH, 4, log2 of entries compared per cycle; legal range 0..ADDR_WIDTH

- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- we  in  1  write din to addr and set its valid bit
- clr_en  in  1  clear valid bit of addr
- din  in  DATA_WIDTH  write data
- addr  in  ADDR_WIDTH  write/clear address
- key_valid  in  1  search key offered
- key  in  DATA_WIDTH  search key
- key_ready  out  1  block can accept a key (high only in IDLE)
- match_valid  out  1  one-cycle result strobe
- match_found  out  1  key hit a valid entry; qualified by match_valid
- match_addr  out  ADDR_WIDTH  lowest matching address; 0 on miss
- busy  out  1  high in SCAN and DONE

## Operation
- Storage: 2**ADDR_WIDTH data words plus valid bits. Reset clears all valid bits; data words are not reset.
- Write port is live in every state. we=1: mem[addr]<=din, valid[addr]<=1. clr_en=1 with we=0: valid[addr]<=0. we and clr_en together: write wins, entry valid.
- Segments: NSEG = 2**(ADDR_WIDTH-LANE_WIDTH); segment s covers addresses s*2**LANE_WIDTH .. (s+1)*2**LANE_WIDTH-1.
- FSM states IDLE, SCAN, DONE.
  - IDLE: key_ready=1. key_valid=1 at edge: latch key, seg<=0, go SCAN. Otherwise stay.
  - SCAN: compare all lanes of segment seg against latched key, requiring valid bit. Any hit: match_addr<=lowest hitting address, match_found<=1, go DONE. No hit and seg==NSEG-1: match_found<=0, match_addr<=0, go DONE. Else seg<=seg+1.
  - DONE: match_valid=1 for exactly this cycle; go IDLE.
- Comparisons use storage contents as registered before the current edge; a write in the same cycle as a segment compare is not seen by that compare.
- Segments are scanned in ascending order and scan stops at first hitting segment, so result is always the lowest valid matching address present when its segment was compared.
- key and key_valid are ignored outside IDLE; the key is not re-sampled during SCAN.
- Segment counter is ADDR_WIDTH-LANE_WIDTH bits; no wrap occurs since scan ends at NSEG-1. LANE_WIDTH=ADDR_WIDTH gives NSEG=1.

## Timing
- Reset values: key_ready=0 during reset, 1 in first cycle after rst deasserts; match_valid=0, match_found=0, match_addr=0, busy=0; FSM IDLE; seg=0.
- Reset mid-SCAN or mid-DONE: abort, no match_valid strobe, all valid bits cleared.
- Key accepted at edge E0. Hit in segment s: match_valid high during cycle after edge E0+s+1, i.e. s+1 cycles after acceptance. Miss: NSEG cycles after acceptance (256 at defaults).
- match_found/match_addr hold their values after DONE until next result.
- Next key acceptable one cycle after DONE; minimum search period s+3 cycles.
- Writes: single-cycle, visible to any compare in a later cycle.

## Test plan
- Reset, then search key 14'h0000 -> miss: match_valid 256 cycles after acceptance, match_found=0, match_addr=0 (stored zeros are invalid).
- Write 14'h1234 at 12'h025, search 14'h1234 -> match_valid 3 cycles after acceptance, match_found=1, match_addr=12'h025; key_ready low from acceptance through DONE.
- Write 14'h0ABC at 12'h300 and 12'h07F, search 14'h0ABC -> match_addr=12'h07F after 8 cycles; then clr_en at 12'h07F, search again -> match_addr=12'h300 after 49 cycles.
- Search 14'h2222 on empty array; during SCAN with seg=10 assert we with din=14'h2222 at 12'hFFF and, same cycle, clr_en+we at 12'h005 -> match_addr=12'hFFF (segment 0 already scanned), entry 12'h005 valid afterwards.
- Compare/write race: with key 14'h0111 accepted and seg=3 being compared, write 14'h0111 at 12'h035 -> segment 3 misses; entry not found, match_found=0 after 256 cycles.
- Assert rst during SCAN at seg=50 -> no match_valid ever, key_ready=1 first cycle after rst drops, previously written keys now miss.
